// File: rtl/phase_to_amplitude_converter.sv
// rtl/phase_to_amplitude_converter.sv - quarter-wave sine PAC with quadrant folding, two-cycle latency
module phase_to_amplitude_converter #(
  parameter int N = 14,
  parameter int P = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         eo,
  input  logic [N-1:0] phase,
  output logic [P-1:0] amplitude
);

  localparam int  quarter = 1 << (N - 2);
  localparam int  amp_max = (1 << (P - 1)) - 1;
  localparam real pi_half = 1.57079632679489661923;

  localparam logic [N-2:0] quarter_idx = {1'b1, {(N-2){1'b0}}};
  localparam logic [P-1:0] mid_code    = {1'b1, {(P-1){1'b0}}};

  // Taylor series keeps the table build free of tool-specific math builtins.
  function automatic logic [P-2:0] rom_entry(input int i);
    real x;
    real term;
    real s;
    int  r;
    x    = pi_half * real'(i) / real'(quarter);
    term = x;
    s    = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    r = $rtoi(real'(amp_max) * s + 0.5);
    if (r > amp_max) r = amp_max;
    if (r < 0) r = 0;
    return r[P-2:0];
  endfunction

  logic [P-2:0] rom [0:quarter];

  for (genvar i = 0; i <= quarter; i++) begin : g_rom
    localparam logic [P-2:0] entry_value = rom_entry(i);
    assign rom[i] = entry_value;
  end

  logic [1:0]   quadrant;
  logic [N-3:0] offset;
  logic [N-2:0] fold_idx;

  assign quadrant = phase[N-1:N-2];
  assign offset   = phase[N-3:0];
  // Odd quadrants mirror the index; offset 0 lands on the table's last entry.
  assign fold_idx = quadrant[0] ? (quarter_idx - {1'b0, offset}) : {1'b0, offset};

  logic [N-2:0] idx_q;
  logic         sign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      idx_q  <= fold_idx;
      sign_q <= quadrant[1];
    end
  end

  logic [P-2:0] entry;
  logic [P-1:0] result;

  assign entry  = rom[idx_q];
  assign result = sign_q ? (mid_code - {1'b0, entry}) : (mid_code + {1'b0, entry});

  always_ff @(posedge clk) begin
    if (rst) begin
      amplitude <= mid_code;
    end else if (eo) begin
      amplitude <= result;
    end else begin
      amplitude <= mid_code;
    end
  end

endmodule

// File: tb/tb_phase_to_amplitude_converter.sv
// tb/tb_phase_to_amplitude_converter.sv - randomized self-checking bench for the sine PAC
module tb_phase_to_amplitude_converter;
  localparam int N = 14;
  localparam int P = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         eo;
  logic [N-1:0] phase;
  logic [P-1:0] amplitude;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  phase_to_amplitude_converter #(.N(N), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .eo        (eo),
    .phase     (phase),
    .amplitude (amplitude)
  );

  function automatic int model(input int p);
    real s;
    real r;
    s = $sin(2.0 * 3.14159265358979323846 * real'(p) / 16384.0);
    r = 2047.0 * s;
    if (r >= 0.0) return 2048 + $rtoi($floor(r + 0.5));
    else          return 2048 - $rtoi($floor(-r + 0.5));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; eo = 1'b0; phase = '0;
    for (int j = 0; j < 4; j++) begin
      if (j == 2) rst = 1'b0;
      step();
      tests++;
      if (amplitude !== 12'd2048) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %0d expected 2048", j, amplitude);
      end
    end
  endtask

  task automatic test_cardinal;
    int ph[4];
    int ex[4];
    ph = '{0, 4096, 8192, 12288};
    ex = '{2048, 4095, 2048, 1};
    eo = 1'b1;
    for (int j = 0; j < 5; j++) begin
      phase = (j < 4) ? ph[j][N-1:0] : '0;
      step();
      if (j >= 1) begin
        tests++;
        if (amplitude !== ex[j-1][P-1:0]) begin
          fails++;
          $display("FAIL cardinal phase %0d: got %0d expected %0d", ph[j-1], amplitude, ex[j-1]);
        end
      end
    end
  endtask

  task automatic test_output_enable;
    phase = 14'd4096; eo = 1'b1;
    step(); step();
    tests++;
    if (amplitude !== 12'd4095) begin
      fails++; $display("FAIL oe_on: got %0d expected 4095", amplitude);
    end
    eo = 1'b0;
    step();
    tests++;
    if (amplitude !== 12'd2048) begin
      fails++; $display("FAIL oe_off: got %0d expected 2048", amplitude);
    end
    eo = 1'b1;
    step();
    tests++;
    if (amplitude !== 12'd4095) begin
      fails++; $display("FAIL oe_back_on: got %0d expected 4095", amplitude);
    end
  endtask

  task automatic test_symmetry;
    int ps[2];
    int ph[3];
    int a[3];
    ps = '{1000, 3000};
    eo = 1'b1;
    foreach (ps[s]) begin
      ph = '{ps[s], 8192 - ps[s], ps[s] + 8192};
      for (int j = 0; j < 4; j++) begin
        phase = (j < 3) ? ph[j][N-1:0] : '0;
        step();
        if (j >= 1) a[j-1] = int'(amplitude);
      end
      tests++;
      if (a[0] != a[1]) begin
        fails++; $display("FAIL sym_mirror p=%0d: got %0d and %0d, expected equal", ps[s], a[0], a[1]);
      end
      tests++;
      if (a[0] + a[2] != 4096) begin
        fails++; $display("FAIL sym_half p=%0d: got sum %0d expected 4096", ps[s], a[0] + a[2]);
      end
      tests++;
      if (a[0] != model(ps[s])) begin
        fails++; $display("FAIL sym_value p=%0d: got %0d expected %0d", ps[s], a[0], model(ps[s]));
      end
    end
  endtask

  task automatic test_random;
    int ph[$];
    int cnt;
    cnt = 1000;
    for (int j = 0; j < cnt; j++) ph.push_back(int'($urandom_range(16383, 0)));
    eo = 1'b1;
    for (int j = 0; j <= cnt; j++) begin
      phase = (j < cnt) ? ph[j][N-1:0] : '0;
      step();
      if (j >= 1) begin
        tests++;
        if (amplitude !== model(ph[j-1])) begin
          fails++;
          $display("FAIL random phase %0d: got %0d expected %0d", ph[j-1], amplitude, model(ph[j-1]));
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    int ex[3];
    ex = '{2048, 2048, 4095};
    eo = 1'b1; phase = 14'd4096;
    step(); step(); step();
    tests++;
    if (amplitude !== 12'd4095) begin
      fails++; $display("FAIL midreset_pre: got %0d expected 4095", amplitude);
    end
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      rst = 1'b0;
      tests++;
      if (amplitude !== ex[j][P-1:0]) begin
        fails++; $display("FAIL midreset edge %0d: got %0d expected %0d", j, amplitude, ex[j]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; eo = 1'b0; phase = '0;
    test_reset();
    test_cardinal();
    test_output_enable();
    test_symmetry();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
